// File: rtl/ps2_key_pkg.sv
// Shared PS/2 set-2 protocol constants and the decoder state encoding
// for the key tracker.
package ps2_key_pkg;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_PAUSE     = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam int         PS2_PAUSE_LEN = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } ps2_state_e;

endpackage

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 make/break sequences and tracks the held state of a
// fixed table of keys, with one-cycle press/release pulses per key.
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int                  N_KEYS         = 4,
    parameter logic [8*N_KEYS-1:0] KEY_CODES      = {8'h72, 8'h75, 8'h1B, 8'h1D},
    parameter logic [N_KEYS-1:0]   KEY_EXT        = 4'b1100,
    parameter int                  TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_code_ready,
    input  logic [7:0]        scan_code,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_down,
    output ps2_state_e        state_dbg
);

    // Handshake: scan_code is meaningful only in a cycle where scan_code_ready
    // is high; there is no back-pressure, every strobe is consumed on its edge.

    localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int                SKIP_W     = $clog2(PS2_PAUSE_LEN + 1);
    localparam logic [SKIP_W-1:0] SKIP_INIT  = SKIP_W'(PS2_PAUSE_LEN);

    ps2_state_e        state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_KEYS-1:0] down_q, down_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;

    logic make_vld;
    logic brk_vld;
    logic code_ext;
    logic clear_all;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            skip_q    <= '0;
            cnt_q     <= '0;
            down_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            cnt_q     <= cnt_d;
            down_q    <= down_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        cnt_d     = '0;
        make_vld  = 1'b0;
        brk_vld   = 1'b0;
        code_ext  = 1'b0;
        clear_all = 1'b0;

        if (state_q == IDLE) begin
            if (scan_code_ready) begin
                case (scan_code)
                    PS2_EXT:    state_d = EXT;
                    PS2_BRK:    state_d = BRK;
                    PS2_PAUSE: begin
                        state_d = SKIP;
                        skip_d  = SKIP_INIT;
                    end
                    PS2_BAT_OK: clear_all = 1'b1;
                    default:    make_vld  = 1'b1;
                endcase
            end
        end else if (scan_code_ready) begin
            // A strobe always wins over a timeout landing in the same cycle.
            case (state_q)
                EXT: begin
                    if (scan_code == PS2_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        make_vld = 1'b1;
                        code_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
                BRK: begin
                    brk_vld = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    brk_vld  = 1'b1;
                    code_ext = 1'b1;
                    state_d  = IDLE;
                end
                SKIP: begin
                    if (skip_q <= SKIP_W'(1)) begin
                        skip_d  = '0;
                        state_d = IDLE;
                    end else begin
                        skip_d = skip_q - SKIP_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            skip_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic hit;
        assign hit          = (scan_code == KEY_CODES[8*i +: 8]) && (code_ext == KEY_EXT[i]);
        assign down_d[i]    = clear_all          ? 1'b0 :
                              (hit && make_vld)  ? 1'b1 :
                              (hit && brk_vld)   ? 1'b0 : down_q[i];
        assign press_d[i]   = down_d[i] & ~down_q[i];
        assign release_d[i] = ~down_d[i] & down_q[i];
    end

    assign key_down    = down_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign any_down    = |down_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a table of single-byte vectors plus
// hand-written sequences for timeout, pause skipping and mid-sequence reset.
module tb_ps2_key_tracker;
    import ps2_key_pkg::*;

    localparam int N = 4;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         scan_code_ready = 1'b0;
    logic [7:0]   scan_code = 8'h00;
    logic [N-1:0] key_down;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic         any_down;
    ps2_state_e   state_dbg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] code;
        logic [3:0] d;
        logic [3:0] p;
        logic [3:0] r;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ps2_key_tracker #(
        .N_KEYS(N),
        .KEY_CODES({8'h72, 8'h75, 8'h1B, 8'h1D}),
        .KEY_EXT(4'b1100),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_code_ready(scan_code_ready),
        .scan_code(scan_code),
        .key_down(key_down),
        .key_press(key_press),
        .key_release(key_release),
        .any_down(any_down),
        .state_dbg(state_dbg)
    );

    function automatic void add(input logic [7:0] code, input logic [3:0] d,
                                input logic [3:0] p, input logic [3:0] r);
        vec_t v;
        v.code = code;
        v.d    = d;
        v.p    = p;
        v.r    = r;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] d,
                              input logic [3:0] p, input logic [3:0] r);
        check({name, ".down"}, 32'(key_down), 32'(d));
        check({name, ".press"}, 32'(key_press), 32'(p));
        check({name, ".release"}, 32'(key_release), 32'(r));
        check({name, ".any"}, 32'(any_down), 32'(|d));
    endtask

    // All drivers start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        scan_code       = b;
        scan_code_ready = 1'b1;
        @(negedge clk);
        scan_code_ready = 1'b0;
        scan_code       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Table: key0=1D, key1=1B, key2=E0 75, key3=E0 72
        add(8'h1D, 4'b0001, 4'b0001, 4'b0000);
        add(8'hF0, 4'b0001, 4'b0000, 4'b0000);
        add(8'h1D, 4'b0000, 4'b0000, 4'b0001);
        add(8'hE0, 4'b0000, 4'b0000, 4'b0000);
        add(8'h75, 4'b0100, 4'b0100, 4'b0000);
        add(8'hE0, 4'b0100, 4'b0000, 4'b0000);
        add(8'hF0, 4'b0100, 4'b0000, 4'b0000);
        add(8'h75, 4'b0000, 4'b0000, 4'b0100);
        add(8'h75, 4'b0000, 4'b0000, 4'b0000);
        add(8'hF0, 4'b0000, 4'b0000, 4'b0000);
        add(8'h75, 4'b0000, 4'b0000, 4'b0000);
        add(8'hE0, 4'b0000, 4'b0000, 4'b0000);
        add(8'hF0, 4'b0000, 4'b0000, 4'b0000);
        add(8'h75, 4'b0000, 4'b0000, 4'b0000);
        add(8'h1D, 4'b0001, 4'b0001, 4'b0000);
        add(8'h1D, 4'b0001, 4'b0000, 4'b0000);
        add(8'h1D, 4'b0001, 4'b0000, 4'b0000);
        add(8'hE0, 4'b0001, 4'b0000, 4'b0000);
        add(8'h72, 4'b1001, 4'b1000, 4'b0000);
        add(8'hAA, 4'b0000, 4'b0000, 4'b1001);
        add(8'hAA, 4'b0000, 4'b0000, 4'b0000);
        add(8'h1B, 4'b0010, 4'b0010, 4'b0000);
        add(8'hE0, 4'b0010, 4'b0000, 4'b0000);
        add(8'h1B, 4'b0010, 4'b0000, 4'b0000);
        add(8'hF0, 4'b0010, 4'b0000, 4'b0000);
        add(8'h1B, 4'b0000, 4'b0000, 4'b0010);
        add(8'hE0, 4'b0000, 4'b0000, 4'b0000);
        add(8'hF0, 4'b0000, 4'b0000, 4'b0000);
        add(8'h72, 4'b0000, 4'b0000, 4'b0000);
        add(8'hE0, 4'b0000, 4'b0000, 4'b0000);
        add(8'h75, 4'b0100, 4'b0100, 4'b0000);
        add(8'h75, 4'b0100, 4'b0000, 4'b0000);
        add(8'hE0, 4'b0100, 4'b0000, 4'b0000);
        add(8'h75, 4'b0100, 4'b0000, 4'b0000);
        add(8'hAA, 4'b0000, 4'b0000, 4'b0100);

        // Reset state while reset is held
        idle(2);
        check_outs("reset", 4'b0000, 4'b0000, 4'b0000);
        check("reset.state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].code);
            check_outs($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].r);
            idle(1);
            check_outs($sformatf("vec%0d_after", i), vecs[i].d, 4'b0000, 4'b0000);
        end

        // Prefix expires after T idle cycles: the following 75 is unprefixed
        send_byte(8'hE0);
        idle(T);
        check("timeout.state", 32'(state_dbg), 32'(IDLE));
        send_byte(8'h75);
        check_outs("timeout_75", 4'b0000, 4'b0000, 4'b0000);
        send_byte(8'hE0);
        idle(T);
        send_byte(8'h72);
        check_outs("timeout_72", 4'b0000, 4'b0000, 4'b0000);

        // Strobe arriving in the cycle the timeout would fire still uses E0
        send_byte(8'hE0);
        idle(T - 1);
        check("pre_timeout.state", 32'(state_dbg), 32'(EXT));
        send_byte(8'h75);
        check_outs("edge_timeout_75", 4'b0100, 4'b0100, 4'b0000);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_outs("edge_timeout_rel", 4'b0000, 4'b0000, 4'b0100);

        // Pause sequence: seven swallowed bytes, key1 held throughout
        send_byte(8'h1B);
        check_outs("skip_pre", 4'b0010, 4'b0010, 4'b0000);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h1B);
        send_byte(8'hAA);
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hF0);
        check("skip_mid.state", 32'(state_dbg), 32'(SKIP));
        send_byte(8'h1D);
        check_outs("skip_end", 4'b0010, 4'b0000, 4'b0000);
        check("skip_end.state", 32'(state_dbg), 32'(IDLE));
        send_byte(8'h1D);
        check_outs("skip_next", 4'b0011, 4'b0001, 4'b0000);
        send_byte(8'hAA);
        check_outs("skip_clear", 4'b0000, 4'b0000, 4'b0011);

        // Asynchronous reset in the middle of E0 F0 with key3 held
        send_byte(8'hE0);
        send_byte(8'h72);
        check_outs("rst_pre", 4'b1000, 4'b1000, 4'b0000);
        send_byte(8'hE0);
        send_byte(8'hF0);
        reset = 1'b1;
        #1;
        check_outs("rst_async", 4'b0000, 4'b0000, 4'b0000);
        check("rst_async.state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        send_byte(8'h72);
        check_outs("rst_72", 4'b0000, 4'b0000, 4'b0000);

        // Reset after a lone E0 must also drop the prefix
        send_byte(8'hE0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        send_byte(8'h72);
        check_outs("rst_e0_72", 4'b0000, 4'b0000, 4'b0000);
        send_byte(8'h1D);
        check_outs("rst_post_1d", 4'b0001, 4'b0001, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
